// File: rtl/scale_coord_if.sv
// Coordinate stream from scale_coord_gen to the line-buffer read / interpolation stage.
interface scale_coord_if #(
    parameter int unsigned INPUT_RES_WIDTH = 11,
    parameter int unsigned FRAC_BITS       = 6
);
    logic                       coordValid;
    logic                       coordReady;
    logic [INPUT_RES_WIDTH-1:0] srcX;
    logic [INPUT_RES_WIDTH-1:0] srcY;
    logic [FRAC_BITS-1:0]       fracX;
    logic [FRAC_BITS-1:0]       fracY;
    logic                       lineStart;
    logic                       lineEnd;
    logic                       frameDone;

    modport master (
        output coordValid, srcX, srcY, fracX, fracY, lineStart, lineEnd, frameDone,
        input  coordReady
    );

    modport slave (
        input  coordValid, srcX, srcY, fracX, fracY, lineStart, lineEnd, frameDone,
        output coordReady
    );
endinterface

// File: rtl/scale_coord_gen.sv
// Raster-order source-coordinate generator for the scaler: integer address + 6-bit phase per output pixel.
// Optional clamping of coordinates to the crop end is enabled by defining SCALE_COORD_CLAMP_EN.
module scale_coord_gen #(
    parameter int unsigned INPUT_RES_WIDTH  = 11,
    parameter int unsigned OUTPUT_RES_WIDTH = 11,
    parameter int unsigned SCALE_BITS       = 8,
    parameter int unsigned FRAC_BITS        = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        inEn,
    input  logic                        iVsyn,
    input  logic [SCALE_BITS-1:0]       kX,
    input  logic [SCALE_BITS-1:0]       kY,
    input  logic [INPUT_RES_WIDTH-1:0]  xBgn,
    input  logic [INPUT_RES_WIDTH-1:0]  xEnd,
    input  logic [INPUT_RES_WIDTH-1:0]  yBgn,
    input  logic [INPUT_RES_WIDTH-1:0]  yEnd,
    input  logic [OUTPUT_RES_WIDTH-1:0] outXRes,
    input  logic [OUTPUT_RES_WIDTH-1:0] outYRes,
    scale_coord_if.master               coord
);
    localparam int unsigned ACC_W = INPUT_RES_WIDTH + FRAC_BITS;

    typedef enum logic [2:0] {IDLE, WAIT_VS, LOAD, RUN, DONE} state_t;

    typedef struct packed {
        logic [SCALE_BITS-1:0]       k_x;
        logic [SCALE_BITS-1:0]       k_y;
        logic [INPUT_RES_WIDTH-1:0]  x_bgn;
        logic [INPUT_RES_WIDTH-1:0]  x_end;
        logic [INPUT_RES_WIDTH-1:0]  y_bgn;
        logic [INPUT_RES_WIDTH-1:0]  y_end;
        logic [OUTPUT_RES_WIDTH-1:0] out_x_res;
        logic [OUTPUT_RES_WIDTH-1:0] out_y_res;
    } cfg_t;

    state_t                      state, state_nxt;
    cfg_t                        cfg, cfg_nxt;
    logic                        vsyn_d;
    logic                        vs_rise;
    logic                        hs;
    logic [ACC_W-1:0]            acc_x, acc_y, acc_x_nxt, acc_y_nxt;
    logic [ACC_W-1:0]            coord_x, coord_y;
    logic [OUTPUT_RES_WIDTH-1:0] cnt_x, cnt_y, cnt_x_nxt, cnt_y_nxt;
    logic                        valid_nxt, line_start_nxt, line_end_nxt, frame_done_nxt;
    logic [INPUT_RES_WIDTH-1:0]  src_x_nxt, src_y_nxt;
    logic [FRAC_BITS-1:0]        frac_x_nxt, frac_y_nxt;

    assign vs_rise = iVsyn & ~vsyn_d;
    assign hs      = coord.coordValid & coord.coordReady;

    // Next-state, datapath and registered-output values
    always_comb begin
        state_nxt = state;
        cfg_nxt   = cfg;
        acc_x_nxt = acc_x;
        acc_y_nxt = acc_y;
        cnt_x_nxt = cnt_x;
        cnt_y_nxt = cnt_y;

        case (state)
            IDLE:    if (inEn) state_nxt = WAIT_VS;
            WAIT_VS: if (vs_rise) state_nxt = LOAD;
            LOAD: begin
                cfg_nxt.k_x       = kX;
                cfg_nxt.k_y       = kY;
                cfg_nxt.x_bgn     = xBgn;
                cfg_nxt.x_end     = xEnd;
                cfg_nxt.y_bgn     = yBgn;
                cfg_nxt.y_end     = yEnd;
                cfg_nxt.out_x_res = outXRes;
                cfg_nxt.out_y_res = outYRes;
                acc_x_nxt         = {xBgn, {FRAC_BITS{1'b0}}};
                acc_y_nxt         = {yBgn, {FRAC_BITS{1'b0}}};
                cnt_x_nxt         = '0;
                cnt_y_nxt         = '0;
                state_nxt         = RUN;
            end
            RUN: begin
                if (vs_rise) begin
                    state_nxt = LOAD;
                end else if (hs) begin
                    if (cnt_x < cfg.out_x_res) begin
                        cnt_x_nxt = cnt_x + OUTPUT_RES_WIDTH'(1);
                        acc_x_nxt = acc_x + ACC_W'(cfg.k_x);
                    end else begin
                        cnt_x_nxt = '0;
                        acc_x_nxt = {cfg.x_bgn, {FRAC_BITS{1'b0}}};
                        acc_y_nxt = acc_y + ACC_W'(cfg.k_y);
                        cnt_y_nxt = cnt_y + OUTPUT_RES_WIDTH'(1);
                        if (cnt_y == cfg.out_y_res) state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = WAIT_VS;
            default: state_nxt = IDLE;
        endcase

        if (!inEn) state_nxt = IDLE;

        coord_x = acc_x_nxt;
        coord_y = acc_y_nxt;
`ifdef SCALE_COORD_CLAMP_EN
        // Past the crop end, sit on the last source pixel with zero phase
        if (acc_x_nxt[ACC_W-1:FRAC_BITS] > cfg_nxt.x_end) coord_x = {cfg_nxt.x_end, {FRAC_BITS{1'b0}}};
        if (acc_y_nxt[ACC_W-1:FRAC_BITS] > cfg_nxt.y_end) coord_y = {cfg_nxt.y_end, {FRAC_BITS{1'b0}}};
`endif

        valid_nxt      = (state_nxt == RUN);
        frame_done_nxt = (state_nxt == DONE);
        src_x_nxt      = '0;
        src_y_nxt      = '0;
        frac_x_nxt     = '0;
        frac_y_nxt     = '0;
        line_start_nxt = 1'b0;
        line_end_nxt   = 1'b0;
        if (valid_nxt) begin
            src_x_nxt      = coord_x[ACC_W-1:FRAC_BITS];
            frac_x_nxt     = coord_x[FRAC_BITS-1:0];
            src_y_nxt      = coord_y[ACC_W-1:FRAC_BITS];
            frac_y_nxt     = coord_y[FRAC_BITS-1:0];
            line_start_nxt = (cnt_x_nxt == '0);
            line_end_nxt   = (cnt_x_nxt == cfg_nxt.out_x_res);
        end
    end

    // FSM state and vsync edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            vsyn_d <= 1'b0;
        end else begin
            state  <= state_nxt;
            vsyn_d <= iVsyn;
        end
    end

    // Shadow config, accumulators, counters and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg              <= '0;
            acc_x            <= '0;
            acc_y            <= '0;
            cnt_x            <= '0;
            cnt_y            <= '0;
            coord.coordValid <= 1'b0;
            coord.srcX       <= '0;
            coord.srcY       <= '0;
            coord.fracX      <= '0;
            coord.fracY      <= '0;
            coord.lineStart  <= 1'b0;
            coord.lineEnd    <= 1'b0;
            coord.frameDone  <= 1'b0;
        end else begin
            cfg              <= cfg_nxt;
            acc_x            <= acc_x_nxt;
            acc_y            <= acc_y_nxt;
            cnt_x            <= cnt_x_nxt;
            cnt_y            <= cnt_y_nxt;
            coord.coordValid <= valid_nxt;
            coord.srcX       <= src_x_nxt;
            coord.srcY       <= src_y_nxt;
            coord.fracX      <= frac_x_nxt;
            coord.fracY      <= frac_y_nxt;
            coord.lineStart  <= line_start_nxt;
            coord.lineEnd    <= line_end_nxt;
            coord.frameDone  <= frame_done_nxt;
        end
    end
endmodule

// File: tb/tb_scale_coord_gen.sv
// Self-checking bench for scale_coord_gen: directed table, hand sequences and random frames vs a pixel-list model.
module tb_scale_coord_gen;
    typedef struct packed {
        logic [7:0]        kx;
        logic [7:0]        ky;
        logic [10:0]       xb;
        logic [10:0]       xe;
        logic [10:0]       yb;
        logic [10:0]       ye;
        logic [10:0]       oxr;
        logic [10:0]       oyr;
        logic [31:0]       n;
        logic [3:0][10:0]  sx;
        logic [3:0][5:0]   fx;
    } vec_t;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [5:0]  fx;
        logic [5:0]  fy;
        logic        ls;
        logic        le;
        logic        fd;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inEn;
    logic        iVsyn;
    logic [7:0]  kX, kY;
    logic [10:0] xBgn, xEnd, yBgn, yEnd, outXRes, outYRes;
    int          checks = 0;
    int          failures = 0;

    scale_coord_if #(.INPUT_RES_WIDTH(11), .FRAC_BITS(6)) coord_bus ();

    scale_coord_gen dut (
        .clk(clk), .rst(rst), .inEn(inEn), .iVsyn(iVsyn),
        .kX(kX), .kY(kY), .xBgn(xBgn), .xEnd(xEnd), .yBgn(yBgn), .yEnd(yEnd),
        .outXRes(outXRes), .outYRes(outYRes), .coord(coord_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int kx, input int ky, input int xb, input int xe,
                                input int yb, input int ye, input int oxr, input int oyr,
                                input int n, input logic [43:0] sx, input logic [23:0] fx);
        vec_t r;
        r.kx = 8'(kx);   r.ky = 8'(ky);
        r.xb = 11'(xb);  r.xe = 11'(xe);
        r.yb = 11'(yb);  r.ye = 11'(ye);
        r.oxr = 11'(oxr); r.oyr = 11'(oyr);
        r.n = 32'(n);
        r.sx = sx;
        r.fx = fx;
        return r;
    endfunction

    function automatic pix_t sample();
        pix_t p;
        p.x  = coord_bus.srcX;
        p.y  = coord_bus.srcY;
        p.fx = coord_bus.fracX;
        p.fy = coord_bus.fracY;
        p.ls = coord_bus.lineStart;
        p.le = coord_bus.lineEnd;
        p.fd = coord_bus.frameDone;
        return p;
    endfunction

    // Source position of output pixel (x,y): begin + index * step, in 1/64 pixel, modulo 2^17
    task automatic build_model(input vec_t v, output pix_t q[$]);
        int unsigned ax, ay;
        pix_t e;
        q = {};
        for (int y = 0; y <= int'(v.oyr); y++) begin
            for (int x = 0; x <= int'(v.oxr); x++) begin
                ax = (int'(v.xb) * 64 + x * int'(v.kx)) % 131072;
                ay = (int'(v.yb) * 64 + y * int'(v.ky)) % 131072;
`ifdef SCALE_COORD_CLAMP_EN
                if (ax / 64 > int'(v.xe)) ax = int'(v.xe) * 64;
                if (ay / 64 > int'(v.ye)) ay = int'(v.ye) * 64;
`endif
                e.x  = 11'(ax / 64);
                e.fx = 6'(ax % 64);
                e.y  = 11'(ay / 64);
                e.fy = 6'(ay % 64);
                e.ls = (x == 0);
                e.le = (x == int'(v.oxr));
                e.fd = 1'b0;
                q.push_back(e);
            end
        end
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready; abort_at: pixel index to vsync-abort at (-1 none)
    task automatic run_frame(input vec_t v, input int mode, input int abort_at, input bit use_tab);
        pix_t q[$];
        pix_t cur, prev;
        int   idx, cyc;
        bit   aborted, stalled, rdy;
        build_model(v, q);
        prev = '0;
        @(negedge clk);
        kX = v.kx; kY = v.ky; xBgn = v.xb; xEnd = v.xe; yBgn = v.yb; yEnd = v.ye;
        outXRes = v.oxr; outYRes = v.oyr;
        coord_bus.coordReady = 1'b0;
        iVsyn = 1'b1;
        @(negedge clk);
        iVsyn = 1'b0;
        check("load_gap_valid", 64'(coord_bus.coordValid), 64'(0));
        @(negedge clk);
        check("first_valid", 64'(coord_bus.coordValid), 64'(1));
        if (abort_at < 0) begin
            kX = 8'($urandom); kY = 8'($urandom);
            xBgn = 11'($urandom); xEnd = 11'($urandom); yBgn = 11'($urandom); yEnd = 11'($urandom);
            outXRes = 11'($urandom); outYRes = 11'($urandom);
        end
        idx = 0; cyc = 0; aborted = 1'b0; stalled = 1'b0;
        while (idx < q.size() && cyc < 4000) begin
            cur = sample();
            check("valid_in_run", 64'(coord_bus.coordValid), 64'(1));
            if (coord_bus.coordValid !== 1'b1) break;
            if (stalled) check("stall_hold", 64'(cur), 64'(prev));
            if (abort_at == idx && !aborted) begin
                iVsyn = 1'b1;
                coord_bus.coordReady = 1'b0;
                @(negedge clk);
                iVsyn = 1'b0;
                check("abort_gap_valid", 64'(coord_bus.coordValid), 64'(0));
                check("abort_no_done", 64'(coord_bus.frameDone), 64'(0));
                @(negedge clk);
                check("restart_valid", 64'(coord_bus.coordValid), 64'(1));
                check("restart_x", 64'(coord_bus.srcX), 64'(v.xb));
                check("restart_y", 64'(coord_bus.srcY), 64'(v.yb));
                idx = 0; aborted = 1'b1; stalled = 1'b0; cyc++;
                continue;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            coord_bus.coordReady = rdy;
            if (rdy) begin
                check("pixel", 64'(cur), 64'(q[idx]));
                if (use_tab && idx < int'(v.n)) begin
                    check("tab_srcx", 64'(cur.x), 64'(v.sx[idx]));
                    check("tab_fracx", 64'(cur.fx), 64'(v.fx[idx]));
                end
                idx++;
            end
            stalled = !rdy;
            prev = cur;
            @(negedge clk);
            cyc++;
        end
        coord_bus.coordReady = 1'b0;
        if (idx < q.size()) begin
            check("frame_timeout", 64'(idx), 64'(q.size()));
        end else begin
            check("frame_done_pulse", 64'(coord_bus.frameDone), 64'(1));
            check("done_valid_low", 64'(coord_bus.coordValid), 64'(0));
            @(negedge clk);
            check("frame_done_single", 64'(coord_bus.frameDone), 64'(0));
            check("wait_valid_low", 64'(coord_bus.coordValid), 64'(0));
        end
    endtask

    initial begin
        vec_t tab[4];
        vec_t v;
        tab[0] = mk(128, 64, 0, 2047, 0, 2047, 3, 1, 4,
                    {11'd6, 11'd4, 11'd2, 11'd0}, {6'd0, 6'd0, 6'd0, 6'd0});
        tab[1] = mk(32, 32, 0, 2047, 0, 2047, 3, 3, 4,
                    {11'd1, 11'd1, 11'd0, 11'd0}, {6'd32, 6'd0, 6'd32, 6'd0});
`ifdef SCALE_COORD_CLAMP_EN
        tab[2] = mk(255, 64, 10, 12, 3, 2047, 3, 1, 4,
                    {11'd12, 11'd12, 11'd12, 11'd10}, {6'd0, 6'd0, 6'd0, 6'd0});
`else
        tab[2] = mk(255, 64, 10, 12, 3, 2047, 3, 1, 4,
                    {11'd21, 11'd17, 11'd13, 11'd10}, {6'd61, 6'd62, 6'd63, 6'd0});
`endif
        tab[3] = mk(200, 200, 5, 2047, 7, 2047, 0, 0, 1,
                    {11'd0, 11'd0, 11'd0, 11'd5}, {6'd0, 6'd0, 6'd0, 6'd0});

        rst = 1'b1; inEn = 1'b0; iVsyn = 1'b0; coord_bus.coordReady = 1'b0;
        kX = '0; kY = '0; xBgn = '0; xEnd = '0; yBgn = '0; yEnd = '0; outXRes = '0; outYRes = '0;
        repeat (2) @(negedge clk);
        // vsync rises while reset is still asserted
        iVsyn = 1'b1; inEn = 1'b1;
        @(negedge clk);
        check("rst_valid", 64'(coord_bus.coordValid), 64'(0));
        check("rst_outputs", 64'(sample()), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        iVsyn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("wait_vs_no_valid", 64'(coord_bus.coordValid), 64'(0));
        end

        for (int i = 0; i < 4; i++) run_frame(tab[i], i % 3, -1, 1'b1);

        v = mk(64, 64, 20, 2047, 30, 2047, 3, 2, 0, '0, '0);
        run_frame(v, 0, 4, 1'b0);

        // Dropping inEn mid-frame kills coordValid on the next edge
        @(negedge clk);
        kX = 8'd64; kY = 8'd64; xBgn = 11'd1; yBgn = 11'd1; outXRes = 11'd7; outYRes = 11'd7;
        iVsyn = 1'b1;
        @(negedge clk);
        iVsyn = 1'b0;
        @(negedge clk);
        check("en_frame_valid", 64'(coord_bus.coordValid), 64'(1));
        coord_bus.coordReady = 1'b1;
        @(negedge clk);
        inEn = 1'b0;
        @(negedge clk);
        coord_bus.coordReady = 1'b0;
        check("en_drop_valid", 64'(coord_bus.coordValid), 64'(0));
        check("en_drop_outputs", 64'(sample()), 64'(0));
        inEn = 1'b1;
        @(negedge clk);
        check("en_restore_idle", 64'(coord_bus.coordValid), 64'(0));

        for (int i = 0; i < 25; i++) begin
            v = mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                   int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 4)), 0, '0, '0);
            run_frame(v, 2, (i % 5 == 4) ? int'($urandom_range(0, 3)) : -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
